// File: rtl/cpu_pkg.sv
// Shared cpu package: fixed-width integer aliases and the iterative divider state type.
package cpu_pkg;

  typedef logic [31:0] uint32_t;
  typedef logic [63:0] uint64_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider, one quotient bit per BUSY cycle.
// Result is {quotient, remainder}; a zero divisor yields {all ones, raw dividend}.
// Optional macro DIV_ZERO_FAST_EN: a zero-divisor accept skips the iterations
// and goes straight to DONE.
module div_iter
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

  localparam int unsigned CW        = $clog2(WIDTH) + 1;
  localparam uint32_t     LAST_STEP = WIDTH - 1;

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             dvs_zero;

  logic             accept;
  logic             last_step;
  logic             in_dvs_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return (SIGNED && x[WIDTH-1]) ? -x : x;
  endfunction

  assign accept      = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign last_step   = (state == BUSY) && (cnt == LAST_STEP[CW-1:0]);
  assign in_dvs_zero = (s_axis_divisor_tdata == '0);

  assign s_axis_dividend_tready = (state == IDLE);
  assign s_axis_divisor_tready  = (state == IDLE);
  assign m_axis_dout_tvalid     = (state == DONE);

  // Restoring step on magnitudes, then sign fix-up of the final step's outputs.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_mag};
    ge       = ~trial[WIDTH];
    rem_step = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], ge};
    q_fix    = neg_q ? -quo_step : quo_step;
    r_fix    = neg_r ? -rem_step : rem_step;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: accept only with both operands valid, WIDTH BUSY steps, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = in_dvs_zero ? DONE : BUSY;
`else
          state_next = BUSY;
`endif
        end
      end
      BUSY:    if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on accept and one iteration per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      dvd_raw  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvs_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= mag(s_axis_dividend_tdata);
      dvs_mag  <= mag(s_axis_divisor_tdata);
      dvd_raw  <= s_axis_dividend_tdata;
      neg_q    <= SIGNED && (s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1]);
      neg_r    <= SIGNED && s_axis_dividend_tdata[WIDTH-1];
      dvs_zero <= in_dvs_zero;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      rem <= rem_step;
      quo <= quo_step;
    end
  end

  // Result register, written only when entering DONE so it holds until the next result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_dout_tdata <= '0;
    end else if (last_step) begin
      m_axis_dout_tdata <= dvs_zero ? {{WIDTH{1'b1}}, dvd_raw} : {q_fix, r_fix};
`ifdef DIV_ZERO_FAST_EN
    end else if (accept && in_dvs_zero) begin
      m_axis_dout_tdata <= {{WIDTH{1'b1}}, s_axis_dividend_tdata};
`endif
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: one unsigned and one signed instance, directed
// cases plus randomized operands checked against an arithmetic reference model.
module tb_div_iter;
  import cpu_pkg::*;

  localparam int LAT = 33;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic    clk = 1'b0;
  logic    reset;
  logic    dvd_valid [2];
  logic    dvs_valid [2];
  uint32_t dvd_data  [2];
  uint32_t dvs_data  [2];
  logic    dvd_ready [2];
  logic    dvs_ready [2];
  logic    out_valid [2];
  uint64_t out_data  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(32), .SIGNED(1'b0)) u_udiv (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tvalid(dvd_valid[0]), .s_axis_dividend_tready(dvd_ready[0]),
    .s_axis_dividend_tdata(dvd_data[0]),
    .s_axis_divisor_tvalid(dvs_valid[0]), .s_axis_divisor_tready(dvs_ready[0]),
    .s_axis_divisor_tdata(dvs_data[0]),
    .m_axis_dout_tvalid(out_valid[0]), .m_axis_dout_tdata(out_data[0])
  );

  div_iter #(.WIDTH(32), .SIGNED(1'b1)) u_sdiv (
    .clk(clk), .reset(reset),
    .s_axis_dividend_tvalid(dvd_valid[1]), .s_axis_dividend_tready(dvd_ready[1]),
    .s_axis_dividend_tdata(dvd_data[1]),
    .s_axis_divisor_tvalid(dvs_valid[1]), .s_axis_divisor_tready(dvs_ready[1]),
    .s_axis_divisor_tdata(dvs_data[1]),
    .m_axis_dout_tvalid(out_valid[1]), .m_axis_dout_tdata(out_data[1])
  );

  // Reference: plain integer division; signed uses truncating division, so the
  // remainder takes the dividend's sign.
  function automatic uint64_t model(input bit sgn, input uint32_t a, input uint32_t b);
    int sa;
    int sb;
    int q;
    int r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (!sgn) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {uint32_t'(q), uint32_t'(r)};
  endfunction

  task automatic chk(input string tag, input uint64_t obs, input uint64_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_tready"}, 64'({dvd_ready[k], dvs_ready[k]}), 64'd3);
      chk({tag, "_tvalid"}, 64'(out_valid[k]), 64'd0);
      chk({tag, "_tdata"}, out_data[k], 64'd0);
    end
  endtask

  // Present one operation, scramble inputs while busy, then check latency, result,
  // one-cycle strobe and data hold.
  task automatic run_op(input int k, input uint32_t a, input uint32_t b,
                        input uint64_t exp, input int exp_lat);
    int n;
    uint64_t held;
    @(negedge clk);
    chk("tready_idle", 64'(dvd_ready[k] & dvs_ready[k]), 64'd1);
    dvd_data[k]  = a;
    dvs_data[k]  = b;
    dvd_valid[k] = 1'b1;
    dvs_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid[k] = 1'b0;
    dvs_valid[k] = 1'b0;
    dvd_data[k]  = $urandom;
    dvs_data[k]  = $urandom;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (out_valid[k]) break;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("result", out_data[k], exp);
    held = out_data[k];
    @(negedge clk);
    chk("strobe_one_cycle", 64'(out_valid[k]), 64'd0);
    chk("tdata_hold", out_data[k], held);
  endtask

  initial begin
    int n;
    int seen;
    uint32_t a;
    uint32_t b;
    int k;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dvd_valid[i] = 1'b0;
      dvs_valid[i] = 1'b0;
      dvd_data[i]  = '0;
      dvs_data[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Directed cases with constant expectations.
    run_op(0, 32'd100, 32'd7, 64'h0000000E_00000002, LAT);
    run_op(1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, LAT);
    run_op(1, 32'd7, 32'hFFFF_FFFE, 64'hFFFFFFFD_00000001, LAT);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, LAT);
    run_op(0, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, ZLAT);
    run_op(1, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, ZLAT);
    run_op(1, 32'hFFFF_FFFB, 32'd0, 64'hFFFFFFFF_FFFFFFFB, ZLAT);

    // A single tvalid must never start an operation.
    @(negedge clk);
    dvd_valid[1] = 1'b1;
    dvd_data[1]  = 32'd9;
    dvs_data[1]  = 32'd3;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid[1] || !dvd_ready[1]) seen++;
      if (i == 20) begin
        dvd_valid[1] = 1'b0;
        dvs_valid[1] = 1'b1;
      end
    end
    dvs_valid[1] = 1'b0;
    chk("single_tvalid_ignored", 64'(seen), 64'd0);

    // Second operation held while BUSY: no accept until after DONE.
    @(negedge clk);
    dvd_data[0]  = 32'd100;
    dvs_data[0]  = 32'd7;
    dvd_valid[0] = 1'b1;
    dvs_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    dvd_data[0] = 32'd200;
    dvs_data[0] = 32'd9;
    n = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (out_valid[0]) break;
      if (dvd_ready[0] || dvs_ready[0]) seen++;
    end
    chk("b2b_busy_tready", 64'(seen), 64'd0);
    chk("b2b_first_latency", 64'(n), 64'(LAT));
    chk("b2b_first_result", out_data[0], 64'h0000000E_00000002);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n++;
      if (dvd_ready[0]) break;
    end
    chk("b2b_ready_after_done", 64'(n), 64'd1);
    @(posedge clk);
    #1;
    dvd_valid[0] = 1'b0;
    dvs_valid[0] = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (out_valid[0]) break;
    end
    chk("b2b_second_latency", 64'(n), 64'(LAT));
    chk("b2b_second_result", out_data[0], model(1'b0, 32'd200, 32'd9));

    // Reset in the middle of BUSY abandons the operation.
    @(negedge clk);
    dvd_data[0]  = 32'd12345;
    dvs_data[0]  = 32'd77;
    dvd_valid[0] = 1'b1;
    dvs_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid[0] = 1'b0;
    dvs_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_busy_reset");
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("no_tvalid_after_abort", 64'(seen), 64'd0);

    // Randomized operands on both instances.
    for (int i = 0; i < 24; i++) begin
      k = i % 2;
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15)) ^ 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      run_op(k, a, b, model(k == 1, a, b), (b == 32'd0) ? ZLAT : LAT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter SIGNED, default 0; 1 selects two's-complement division, 0 selects unsigned division.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port s_axis_dividend_tvalid, input, 1: the dividend is valid.
REQ-006 SHALL have port s_axis_dividend_tready, output, 1: the block can accept a dividend.
REQ-007 SHALL have port s_axis_dividend_tdata, input, WIDTH: the dividend.
REQ-008 SHALL have port s_axis_divisor_tvalid, input, 1: the divisor is valid.
REQ-009 SHALL have port s_axis_divisor_tready, output, 1: the block can accept a divisor.
REQ-010 SHALL have port s_axis_divisor_tdata, input, WIDTH: the divisor.
REQ-011 SHALL have port m_axis_dout_tvalid, output, 1: one-cycle result strobe; there is no backpressure.
REQ-012 SHALL have port m_axis_dout_tdata, output, 2*WIDTH: the result, {quotient, remainder}, with the quotient in the upper half.

Function
REQ-013 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-014 SHALL drive both tready outputs high exactly when the state is IDLE.
REQ-015 SHALL accept an operation only in IDLE on a cycle where both tvalid inputs are high; a single tvalid SHALL be ignored.
REQ-016 SHALL, on accept, latch both operands, clear the iteration counter and enter BUSY.
REQ-017 SHALL perform one restoring radix-2 step per BUSY cycle, WIDTH steps in total, then enter DONE.
REQ-018 SHALL assert m_axis_dout_tvalid for exactly the one DONE cycle, then return to IDLE.
REQ-019 SHALL give a latency from the accept edge to the tvalid cycle of WIDTH+1 cycles (33 cycles at the default).
REQ-020 SHALL allow a new accept on the cycle after DONE; the back-to-back throughput is one result per WIDTH+2 cycles.
REQ-021 SHALL hold m_axis_dout_tdata stable from DONE until the next DONE.
REQ-022 SHALL, with SIGNED=1, divide the operand magnitudes, then negate the quotient if the operand signs differ and give the remainder the sign of the dividend.
REQ-023 SHALL, for SIGNED=1 and -2^(WIDTH-1) / -1, return quotient 0x80000000 and remainder 0 (at WIDTH=32).
REQ-024 SHALL, on a zero divisor, return a quotient of all ones and a remainder equal to the raw dividend, in both modes.
REQ-025 SHALL ignore input tdata changes while in BUSY or DONE.

Reset
REQ-026 SHALL, while reset is high, force the state to IDLE, both tready outputs to 1, m_axis_dout_tvalid to 0, m_axis_dout_tdata to 0 and the counter to 0.
REQ-027 SHALL abandon any operation in progress when reset is asserted, with no tvalid for it after reset is released.

Configuration
REQ-028 SHALL use the macro DIV_ZERO_FAST_EN.
REQ-029 SHALL, with DIV_ZERO_FAST_EN defined, make a zero-divisor accept go directly to DONE, so tvalid rises on the next cycle (latency 1) with the REQ-024 result.
REQ-030 SHALL, without DIV_ZERO_FAST_EN, run the full WIDTH iterations for a zero divisor (latency WIDTH+1) and produce the identical REQ-024 result.

Structure
REQ-031 SHALL take uint32_t and uint64_t from the shared cpu package.
REQ-032 SHALL add a div_state_t enum (IDLE, BUSY, DONE) to the shared cpu package.
REQ-033 SHALL be a single module with no sub-modules; the sign fix-up logic is inline.

Verification
REQ-034 SHALL cover: SIGNED=0, 100/7 -> tdata 0x0000000E_00000002, tvalid high at cycle 33 after accept, high for one cycle only.
REQ-035 SHALL cover: SIGNED=1, -7/2 -> tdata 0xFFFFFFFD_FFFFFFFF; and 7/-2 -> tdata 0xFFFFFFFD_00000001.
REQ-036 SHALL cover: SIGNED=1, 0x80000000/0xFFFFFFFF -> tdata 0x80000000_00000000.
REQ-037 SHALL cover: 5/0 -> tdata 0xFFFFFFFF_00000005; latency 1 with DIV_ZERO_FAST_EN, 33 without.
REQ-038 SHALL cover: a second operation presented while BUSY -> tready stays 0 and no accept until after DONE; the second result follows its own accept by 33 cycles.
REQ-039 SHALL cover: reset asserted at cycle 10 of BUSY -> outputs take REQ-026 values immediately and no tvalid appears for the abandoned operation.
